// File: rtl/load_store_unit.sv
// load_store_unit: owns every data-memory access for the core.
// Takes a byte/half/word load or store and produces the word address, write
// byte mask and lane-aligned write data. A load result is assembled and then
// sign- or zero-extended. An access that crosses a word boundary is split into
// two word accesses back to back. The core stalls while reqReady is low.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int MEM_WORDS        = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWe,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic [31:0] memAddr,
  output logic [3:0]  memWMask,
  output logic [31:0] memWd,
  input  logic [31:0] memRd,
  output logic        respValid,
  output logic        respErr,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  localparam logic [31:0] MW = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, w0_q, rdata_q;

  // ---------------------------------------------------------------------------
  // Request decode on the incoming request. This is only used at accept time.
  // ---------------------------------------------------------------------------
  logic [2:0]  req_n;
  logic [3:0]  req_end;
  logic [29:0] req_idx0, req_idx1;
  logic        req_legal, req_split, req_oor, req_err;

  // Size, boundary crossing, range and legality checks for a new request.
  always_comb begin
    case (reqFunct3[1:0])
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
    req_end   = {2'b00, reqAddr[1:0]} + {1'b0, req_n};
    req_split = (req_end > 4'd4);
    req_idx0  = reqAddr[31:2];
    // The second word index wraps with the 32-bit address.
    req_idx1  = reqAddr[31:2] + 30'd1;
    req_legal = ((reqFunct3 == 3'b000) || (reqFunct3 == 3'b001) || (reqFunct3 == 3'b010) ||
                 (reqFunct3 == 3'b100) || (reqFunct3 == 3'b101)) && !(reqWe && reqFunct3[2]);
    req_oor   = ({2'b00, req_idx0} >= MW) || (req_split && ({2'b00, req_idx1} >= MW));
    req_err   = !req_legal || (req_split && !ALLOW_MISALIGNED) || req_oor;
  end

  // ---------------------------------------------------------------------------
  // Decode of the latched request.
  // ---------------------------------------------------------------------------
  logic [2:0] n_q;
  logic [1:0] o_q;
  logic       split_q;

  // Size, offset and split flag of the request currently in flight.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   n_q = 3'd1;
      2'b01:   n_q = 3'd2;
      default: n_q = 3'd4;
    endcase
    o_q     = addr_q[1:0];
    split_q = (({2'b00, o_q} + {1'b0, n_q}) > 4'd4);
  end

  // ---------------------------------------------------------------------------
  // Memory-side lane steering for the current access cycle.
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] wbytes, wd_c;
  logic [3:0]      mask_c;
  logic            in_acc, acc2;
  logic [3:0]      pos, bi;

  // Map each memory lane back to its request byte. ACC2 covers byte positions 4..7.
  always_comb begin
    wbytes  = wdata_q;
    wd_c    = '0;
    mask_c  = '0;
    memAddr = '0;
    pos     = '0;
    bi      = '0;
    in_acc  = (state_q == ACC1) || (state_q == ACC2);
    acc2    = (state_q == ACC2);
    if (state_q == ACC1) memAddr = {addr_q[31:2], 2'b00};
    if (acc2)            memAddr = {addr_q[31:2], 2'b00} + 32'd4;
    for (int l = 0; l < 4; l++) begin
      pos = 4'(l) + (acc2 ? 4'd4 : 4'd0);
      bi  = pos - {2'b00, o_q};
      if (in_acc && we_q && (pos >= {2'b00, o_q}) && (bi < {1'b0, n_q})) begin
        mask_c[l] = 1'b1;
        wd_c[l]   = wbytes[bi[1:0]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load assembly. In ACC1 the first word is still on memRd; in ACC2 it was
  // captured into w0_q and memRd holds the second word.
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] src0, src1, gath;
  logic [31:0]     gw, ld_res;
  logic [3:0]      p;

  // Gather request bytes 0..n-1 from their lanes, then extend by funct3.
  always_comb begin
    src0 = (state_q == ACC1) ? memRd : w0_q;
    src1 = memRd;
    gath = '0;
    p    = '0;
    for (int i = 0; i < 4; i++) begin
      p = {2'b00, o_q} + 4'(i);
      if (4'(i) < {1'b0, n_q})
        gath[i] = (p < 4'd4) ? src0[p[1:0]] : src1[p[1:0]];
    end
    gw = gath;
    case (f3_q)
      3'b000:  ld_res = {{24{gw[7]}}, gw[7:0]};
      3'b001:  ld_res = {{16{gw[15]}}, gw[15:0]};
      3'b100:  ld_res = {24'd0, gw[7:0]};
      3'b101:  ld_res = {16'd0, gw[15:0]};
      default: ld_res = gw;
    endcase
  end

  // Next-state logic for IDLE -> ACC1 -> [ACC2] -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (reqValid) state_d = req_err ? RESP : ACC1;
      ACC1:    state_d = split_q ? ACC2 : RESP;
      ACC2:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, request latch, first-word capture and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      w0_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (reqValid) begin
          we_q    <= reqWe;
          f3_q    <= reqFunct3;
          addr_q  <= reqAddr;
          wdata_q <= reqWdata;
          err_q   <= req_err;
          rdata_q <= '0;
        end
        ACC1: begin
          w0_q <= memRd;
          if (!split_q) rdata_q <= we_q ? 32'd0 : ld_res;
        end
        ACC2: rdata_q <= we_q ? 32'd0 : ld_res;
        RESP: rdata_q <= '0;
        default: ;
      endcase
    end
  end

  // The mask is gated by reset so that a store caught mid-flight never writes.
  assign memWMask  = reset ? 4'd0 : mask_c;
  assign memWd     = wd_c;
  assign reqReady  = (state_q == IDLE) && !reset;
  assign respValid = (state_q == RESP) && !reset;
  assign respErr   = respValid && err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. The main instance uses the default
// parameters. A second instance with ALLOW_MISALIGNED=0 shares its inputs.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqWe;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWdata;
  logic        reqReady, respValid, respErr;
  logic [31:0] memAddr, memWd, memRd, rdata;
  logic [3:0]  memWMask;
  logic        na_reqReady, na_respValid, na_respErr;
  logic [31:0] na_memAddr, na_memWd, na_memRd, na_rdata;
  logic [3:0]  na_memWMask;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady), .reqWe(reqWe),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWdata(reqWdata), .memAddr(memAddr),
    .memWMask(memWMask), .memWd(memWd), .memRd(memRd), .respValid(respValid),
    .respErr(respErr), .rdata(rdata)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0), .MEM_WORDS(256)) na (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(na_reqReady), .reqWe(reqWe),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWdata(reqWdata), .memAddr(na_memAddr),
    .memWMask(na_memWMask), .memWd(na_memWd), .memRd(na_memRd), .respValid(na_respValid),
    .respErr(na_respErr), .rdata(na_rdata)
  );

  assign memRd    = mem[memAddr[9:2]];
  assign na_memRd = mem[na_memAddr[9:2]];

  // Byte-masked memory model driven by the main instance only.
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (memWMask[b]) mem[memAddr[9:2]][8*b +: 8] <= memWd[8*b +: 8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, then take the accept edge and withdraw it.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = a; reqWdata = d;
    tick();
    reqValid = 1'b0;
  endtask

  // Issue a request and expect respValid exactly lat cycles after the accept edge.
  task automatic run_acc(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input logic [31:0] exp_rd,
                         input logic exp_err, input string tag);
    issue(we, f3, a, d);
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_early_rv"}, {31'd0, respValid}, 32'd0);
      tick();
    end
    chk({tag, "_rv"}, {31'd0, respValid}, 32'd1);
    chk({tag, "_err"}, {31'd0, respErr}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_mask"}, {28'd0, memWMask}, 32'd0);
    tick();
    chk({tag, "_ready"}, {31'd0, reqReady}, 32'd1);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    reset = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqFunct3 = 3'b000;
    reqAddr = 32'd0; reqWdata = 32'd0;
    tick(); tick();
    chk("rst_ready", {31'd0, reqReady}, 32'd0);
    chk("rst_mask", {28'd0, memWMask}, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", {31'd0, reqReady}, 32'd1);
    chk("idle_addr", memAddr, 32'd0);
    chk("idle_rdata", rdata, 32'd0);
    chk("idle_rv", {31'd0, respValid}, 32'd0);

    // Aligned SW
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_addr", memAddr, 32'h10);
    chk("sw_mask", {28'd0, memWMask}, 32'hF);
    chk("sw_wd", memWd, 32'hDEADBEEF);
    chk("sw_busy", {31'd0, reqReady}, 32'd0);
    chk("sw_rv_acc", {31'd0, respValid}, 32'd0);
    tick();
    chk("sw_rv", {31'd0, respValid}, 32'd1);
    chk("sw_err", {31'd0, respErr}, 32'd0);
    chk("sw_rdata", rdata, 32'd0);
    chk("sw_mask_resp", {28'd0, memWMask}, 32'd0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    tick();

    // Byte and half loads with sign and zero extension
    mem[4] <= 32'h80112233;
    issue(1'b0, 3'b000, 32'h13, 32'd0);
    chk("lb_addr", memAddr, 32'h10);
    chk("lb_mask", {28'd0, memWMask}, 32'd0);
    tick();
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    tick();
    run_acc(1'b0, 3'b100, 32'h13, 32'd0, 2, 32'h00000080, 1'b0, "lbu");
    run_acc(1'b0, 3'b001, 32'h12, 32'd0, 2, 32'hFFFF8011, 1'b0, "lh");
    run_acc(1'b0, 3'b010, 32'h10, 32'd0, 2, 32'h80112233, 1'b0, "lw");

    // Split SH across the word boundary
    mem[3] <= 32'd0; mem[4] <= 32'd0;
    issue(1'b1, 3'b001, 32'h0F, 32'h0000ABCD);
    chk("sh_a1_addr", memAddr, 32'h0C);
    chk("sh_a1_mask", {28'd0, memWMask}, 32'h8);
    chk("sh_a1_wd", memWd, 32'hCD000000);
    tick();
    chk("sh_a2_addr", memAddr, 32'h10);
    chk("sh_a2_mask", {28'd0, memWMask}, 32'h1);
    chk("sh_a2_wd", memWd, 32'h000000AB);
    chk("sh_a2_rv", {31'd0, respValid}, 32'd0);
    tick();
    chk("sh_rv", {31'd0, respValid}, 32'd1);
    chk("sh_mem3", mem[3], 32'hCD000000);
    chk("sh_mem4", mem[4], 32'h000000AB);
    tick();

    // Split LW: the main instance splits it, the strict instance rejects it
    issue(1'b0, 3'b010, 32'h0E, 32'd0);
    chk("na_rv", {31'd0, na_respValid}, 32'd1);
    chk("na_err", {31'd0, na_respErr}, 32'd1);
    chk("na_rdata", na_rdata, 32'd0);
    chk("na_mask", {28'd0, na_memWMask}, 32'd0);
    chk("lws_rv_a1", {31'd0, respValid}, 32'd0);
    tick();
    chk("na_rv_after", {31'd0, na_respValid}, 32'd0);
    chk("lws_rv_a2", {31'd0, respValid}, 32'd0);
    tick();
    chk("lws_rv", {31'd0, respValid}, 32'd1);
    chk("lws_rdata", rdata, 32'h00ABCD00);
    tick();
    run_acc(1'b0, 3'b001, 32'h0F, 32'd0, 3, 32'hFFFFABCD, 1'b0, "lhs");
    run_acc(1'b0, 3'b101, 32'h0F, 32'd0, 3, 32'h0000ABCD, 1'b0, "lhus");

    // Errors and range boundaries
    mem[255] <= 32'h12345678;
    run_acc(1'b0, 3'b011, 32'h20, 32'd0, 1, 32'd0, 1'b1, "f3_011");
    run_acc(1'b1, 3'b100, 32'h20, 32'hFF, 1, 32'd0, 1'b1, "sbu_ill");
    run_acc(1'b0, 3'b010, 32'h400, 32'd0, 1, 32'd0, 1'b1, "lw_oor");
    run_acc(1'b0, 3'b010, 32'h3FC, 32'd0, 2, 32'h12345678, 1'b0, "lw_last");
    run_acc(1'b0, 3'b001, 32'h3FF, 32'd0, 1, 32'd0, 1'b1, "lh_oor2");
    run_acc(1'b1, 3'b000, 32'h21, 32'h1234565A, 2, 32'd0, 1'b0, "sb");
    chk("sb_mem", mem[8], 32'h00005A00);

    // reqValid held high: an accept is only possible from IDLE, every other cycle
    reqValid = 1'b1; reqWe = 1'b0; reqFunct3 = 3'b011; reqAddr = 32'd0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (respValid) cnt++;
    end
    reqValid = 1'b0;
    chk("held_count", 32'(cnt), 32'd3);

    // Reset during ACC2 of a split SW
    mem[3] <= 32'd0;
    issue(1'b1, 3'b010, 32'h0E, 32'h11223344);
    chk("rsw_a1_mask", {28'd0, memWMask}, 32'hC);
    chk("rsw_a1_wd", memWd, 32'h33440000);
    tick();
    chk("rsw_a2_mask", {28'd0, memWMask}, 32'h3);
    reset = 1'b1;
    #1;
    chk("rsw_rst_mask", {28'd0, memWMask}, 32'd0);
    chk("rsw_rst_rv", {31'd0, respValid}, 32'd0);
    tick();
    chk("rsw_rst_ready", {31'd0, reqReady}, 32'd0);
    chk("rsw_rst_rv2", {31'd0, respValid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rsw_ready", {31'd0, reqReady}, 32'd1);
    tick();
    chk("rsw_no_rv", {31'd0, respValid}, 32'd0);
    chk("rsw_mem3", mem[3], 32'h33440000);
    chk("rsw_mem4", mem[4], 32'h000000AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
